// File: rtl/econet_pkg.sv
// Shared constants for the Econet line-control block: register offsets and
// bit positions within CTRL and STATUS, plus the byte-lane write helper.
package econet_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_MARK   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_CLKEN  = 0;
    localparam int CTRL_TERMEN = 1;
    localparam int CTRL_IE     = 2;
    localparam int CTRL_W      = 3;

    localparam int STAT_PEND  = 0;
    localparam int STAT_LEVEL = 1;

    // Merge new_v into old_v on the byte lanes whose strobe is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/econet_clkgen_ctl_if.sv
// CPU peripheral bus seen by the Econet line-control block.
interface econet_clkgen_ctl_if;

    logic        select;
    logic [1:0]  addr;
    logic [3:0]  wr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output select, output addr, output wr, output data_in, input data_out);
    modport slave  (input select, input addr, input wr, input data_in, output data_out);

endinterface

// File: rtl/econet_clk_divider.sv
// Clock-enable style divider producing the Econet line clock. PERIOD and MARK
// are shadowed and only picked up at a period boundary (or while disabled), so
// a register write can never shorten or split the phase currently on the pin.
module econet_clk_divider #(
    parameter int DIV_W      = 16,
    parameter int DEF_PERIOD = 99,
    parameter int DEF_MARK   = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    input  logic [DIV_W-1:0] mark,
    output logic             clkout
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] per_act;
    logic [DIV_W-1:0] mark_act;
    logic             wrap;

    assign wrap = (cnt == per_act);

    // Period counter, shadow reload at wrap or while disabled, registered pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every flop here, shadows included, is reset so the pin
            // restarts from a known clean phase with no partial pulse.
            cnt      <= '0;
            per_act  <= DIV_W'(DEF_PERIOD);
            mark_act <= DIV_W'(DEF_MARK);
            clkout   <= 1'b0;
        end else if (!en) begin
            cnt      <= '0;
            per_act  <= period;
            mark_act <= mark;
            clkout   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge cnt/mark_act; blocking here would skew the pin by one.
            clkout <= (cnt < mark_act);
            if (wrap) begin
                cnt      <= '0;
                per_act  <= period;
                mark_act <= mark;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/econet_clkgen_ctl.sv
// Econet line-control block: CTRL/PERIOD/MARK/STATUS registers, collision
// synchroniser with sticky pending flag, and the line clock divider.
module econet_clkgen_ctl
    import econet_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEF_PERIOD  = 99,
    parameter int DEF_MARK    = 25,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    econet_clkgen_ctl_if.slave   bus,
    input  logic                 collision_detect,
    output logic                 econet_clken,
    output logic                 econet_termen,
    output logic                 econet_clkout,
    output logic                 coldet_interrupt
);

    logic [CTRL_W-1:0]      ctrl_q;
    logic [DIV_W-1:0]       period_q;
    logic [DIV_W-1:0]       mark_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   pending_q;
    logic                   wr_any;
    logic                   coll_rise;
    logic                   pend_clr;
    logic                   sync_lvl;
    logic [31:0]            rdata;
    logic                   unused_data;

    assign wr_any    = bus.select && (|bus.wr);
    assign sync_lvl  = sync_q[SYNC_STAGES-1];
    assign coll_rise = sync_lvl && !sync_prev_q;
    assign pend_clr  = wr_any && (bus.addr == REG_STATUS) && bus.wr[0] && bus.data_in[STAT_PEND];

    // Register file writes with byte-lane strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            period_q <= DIV_W'(DEF_PERIOD);
            mark_q   <= DIV_W'(DEF_MARK);
        end else if (wr_any) begin
            if (bus.addr == REG_CTRL && bus.wr[0])
                ctrl_q <= bus.data_in[CTRL_W-1:0];
            if (bus.addr == REG_PERIOD)
                period_q <= DIV_W'(byte_merge(32'(period_q), bus.data_in, bus.wr));
            if (bus.addr == REG_MARK)
                mark_q <= DIV_W'(byte_merge(32'(mark_q), bus.data_in, bus.wr));
        end
    end

    // Collision synchroniser, edge history and sticky pending (set beats clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], collision_detect};
            sync_prev_q <= sync_lvl;
            pending_q   <= coll_rise || (pending_q && !pend_clr);
        end
    end

    // Combinational read mux; unused bits read as zero.
    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        rdata = '0;
        case (bus.addr)
            REG_CTRL:   rdata[CTRL_W-1:0] = ctrl_q;
            REG_PERIOD: rdata[DIV_W-1:0]  = period_q;
            REG_MARK:   rdata[DIV_W-1:0]  = mark_q;
            REG_STATUS: begin
                rdata[STAT_PEND]  = pending_q;
                rdata[STAT_LEVEL] = sync_lvl;
            end
            default:    rdata = '0;
        endcase
    end

    assign bus.data_out     = rdata;
    assign econet_clken     = ctrl_q[CTRL_CLKEN];
    assign econet_termen    = ctrl_q[CTRL_TERMEN];
    assign coldet_interrupt = pending_q && ctrl_q[CTRL_IE];
    assign unused_data      = ^bus.data_in;

    econet_clk_divider #(
        .DIV_W      (DIV_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_MARK   (DEF_MARK)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .en     (ctrl_q[CTRL_CLKEN]),
        .period (period_q),
        .mark   (mark_q),
        .clkout (econet_clkout)
    );

endmodule
